z80_bus_seq: RTL and testbench

//  Parametrised Z80 bus-cycle sequencer: turns abstract cycle requests (fetch, mem/io rd/wr, int-ack)

---
 rtl/z80_bus_pkg.sv | 46 ++++
 rtl/z80_wait_gen.sv | 33 +++
 rtl/z80_bus_seq.sv | 196 +++++++++++++++++++
 tb/tb_z80_bus_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus-cycle sequencer: cycle kinds, T-states and
// small helpers that classify a cycle kind.
package z80_bus_pkg;

  localparam int AUTO_W = 3;

  typedef enum logic [2:0] {
    CYC_M1    = 3'd0,
    CYC_MEMRD = 3'd1,
    CYC_MEMWR = 3'd2,
    CYC_IORD  = 3'd3,
    CYC_IOWR  = 3'd4,
    CYC_INTA  = 3'd5
  } cycle_t;

  typedef enum logic [2:0] {
    TS_IDLE  = 3'd0,
    TS_T1    = 3'd1,
    TS_T2    = 3'd2,
    TS_TW    = 3'd3,
    TS_T3    = 3'd4,
    TS_T4    = 3'd5,
    TS_GRANT = 3'd6
  } tstate_t;

  // Codes 6 and 7 are spare and behave as a plain memory read.
  function automatic cycle_t decode_type(input logic [2:0] code);
    case (code)
      3'd0:    return CYC_M1;
      3'd2:    return CYC_MEMWR;
      3'd3:    return CYC_IORD;
      3'd4:    return CYC_IOWR;
      3'd5:    return CYC_INTA;
      default: return CYC_MEMRD;
    endcase
  endfunction

  function automatic logic has_rfsh(input cycle_t c);
    return (c == CYC_M1) || (c == CYC_INTA);
  endfunction

  function automatic logic is_read(input cycle_t c);
    return (c == CYC_M1) || (c == CYC_MEMRD) || (c == CYC_IORD) || (c == CYC_INTA);
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Automatic wait-state counter: loaded at cycle accept, counts down once per
// TW entered, and merges with the external wait_n to decide whether to stay in TW.
module z80_wait_gen
  import z80_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              load,
  input  logic [AUTO_W-1:0] load_val,
  input  logic              in_window,
  input  logic              wait_n,
  output logic              stay_tw
);

  logic [AUTO_W-1:0] count;

  // wait_n only matters while the sequencer is in T2 or TW.
  assign stay_tw = in_window && ((count != '0) || !wait_n);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (cen) begin
      if (load) begin
        count <= load_val;
      end else if (stay_tw && (count != '0)) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_bus_seq.sv
// Z80 bus-cycle sequencer: turns abstract cycle requests into T-state accurate
// bus strobes with auto waits, refresh, bus request/grant and cycle chaining.
module z80_bus_seq
  import z80_bus_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int INTA_WAIT = 2,
  parameter int T2_WRITE  = 1,
  parameter int RFSH_EN   = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cen,
  input  logic          req,
  input  logic [2:0]    req_type,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [AW-1:0] rfsh_addr,
  input  logic [DW-1:0] di,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] rdata,
  input  logic          wait_n,
  input  logic          busrq_n,
  output logic          busak_n,
  output logic          bus_oe,
  output logic [AW-1:0] A,
  output logic [DW-1:0] dout,
  output logic          m1_n,
  output logic          mreq_n,
  output logic          iorq_n,
  output logic          rd_n,
  output logic          wr_n,
  output logic          rfsh_n,
  output logic [2:0]    tstate
);

  tstate_t state, state_nx;
  cycle_t  cyc, cyc_nx, req_cyc;
  logic    accept, finish, latch_rd, stay_tw, final_st;
  logic    m1_low, mreq_low, iorq_low, rd_low, wr_low, rfsh_low;
  logic    in_t1, in_t2, in_tw, in_t3, in_t4;

  function automatic logic [AUTO_W-1:0] auto_wait(input cycle_t c);
    case (c)
      CYC_IORD, CYC_IOWR: return AUTO_W'(IO_WAIT);
      CYC_INTA:           return AUTO_W'(INTA_WAIT);
      default:            return AUTO_W'(MEM_WAIT);
    endcase
  endfunction

  assign req_cyc  = decode_type(req_type);
  assign final_st = (state == TS_T4) || ((state == TS_T3) && !has_rfsh(cyc));
  assign tstate   = state;

  // Handshake: ready is high in IDLE or in the last T-state of a cycle while the
  // bus is not requested; a cycle is taken on a clk edge with req & ready & cen.
  assign ready = ((state == TS_IDLE) || final_st) && busrq_n;

  z80_wait_gen u_wait_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .cen       (cen),
    .load      (accept),
    .load_val  (auto_wait(req_cyc)),
    .in_window ((state == TS_T2) || (state == TS_TW)),
    .wait_n    (wait_n),
    .stay_tw   (stay_tw)
  );

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    accept   = 1'b0;
    finish   = 1'b0;
    latch_rd = 1'b0;
    case (state)
      TS_IDLE: begin
        if (!busrq_n) state_nx = TS_GRANT;
        else if (req) accept = 1'b1;
      end
      TS_T1: state_nx = TS_T2;
      TS_T2, TS_TW: begin
        state_nx = stay_tw ? TS_TW : TS_T3;
        latch_rd = !stay_tw && is_read(cyc);
      end
      TS_T3: begin
        if (has_rfsh(cyc)) state_nx = TS_T4;
        else finish = 1'b1;
      end
      TS_T4:    finish = 1'b1;
      TS_GRANT: if (busrq_n) state_nx = TS_IDLE;
      default:  state_nx = TS_IDLE;
    endcase
    // A pending bus request wins over a chained cycle at the end of a cycle.
    if (finish) begin
      if (!busrq_n) state_nx = TS_GRANT;
      else if (req) accept = 1'b1;
      else state_nx = TS_IDLE;
    end
    if (accept) begin
      state_nx = TS_T1;
      cyc_nx   = req_cyc;
    end
  end

  // Strobes come from the next state so each is stable for its whole T-state.
  always_comb begin
    m1_low   = 1'b0;
    mreq_low = 1'b0;
    iorq_low = 1'b0;
    rd_low   = 1'b0;
    wr_low   = 1'b0;
    rfsh_low = 1'b0;
    in_t1    = (state_nx == TS_T1);
    in_t2    = (state_nx == TS_T2);
    in_tw    = (state_nx == TS_TW);
    in_t3    = (state_nx == TS_T3);
    in_t4    = (state_nx == TS_T4);
    case (cyc_nx)
      CYC_M1: begin
        m1_low   = in_t1 || in_t2 || in_tw;
        mreq_low = in_t2 || in_tw || (in_t3 && (RFSH_EN != 0));
        rd_low   = in_t2 || in_tw;
        rfsh_low = in_t3 || in_t4;
      end
      CYC_MEMRD: begin
        mreq_low = in_t2 || in_tw || in_t3;
        rd_low   = in_t2 || in_tw || in_t3;
      end
      CYC_MEMWR: begin
        mreq_low = in_t2 || in_tw || in_t3;
        wr_low   = (in_t2 && (T2_WRITE != 0)) || in_tw || in_t3;
      end
      CYC_IORD: begin
        iorq_low = in_t2 || in_tw || in_t3;
        rd_low   = in_t2 || in_tw || in_t3;
      end
      CYC_IOWR: begin
        iorq_low = in_t2 || in_tw || in_t3;
        wr_low   = (in_t2 && (T2_WRITE != 0)) || in_tw || in_t3;
      end
      CYC_INTA: begin
        m1_low   = in_t1 || in_t2 || in_tw;
        iorq_low = in_tw;
        mreq_low = in_t3 && (RFSH_EN != 0);
        rfsh_low = in_t3 || in_t4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= TS_IDLE;
      cyc     <= CYC_M1;
      m1_n    <= 1'b1;
      mreq_n  <= 1'b1;
      iorq_n  <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      rfsh_n  <= 1'b1;
      busak_n <= 1'b1;
      bus_oe  <= 1'b1;
      A       <= '0;
      dout    <= '0;
      rdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= cen && finish;
      if (cen) begin
        state   <= state_nx;
        cyc     <= cyc_nx;
        m1_n    <= !m1_low;
        mreq_n  <= !mreq_low;
        iorq_n  <= !iorq_low;
        rd_n    <= !rd_low;
        wr_n    <= !wr_low;
        rfsh_n  <= !rfsh_low;
        busak_n <= (state_nx != TS_GRANT);
        bus_oe  <= (state_nx != TS_GRANT);
        if (accept) begin
          A    <= req_addr;
          dout <= req_wdata;
        end else if ((state_nx == TS_T3) && has_rfsh(cyc)) begin
          A <= rfsh_addr;
        end
        if (latch_rd) rdata <= di;
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_seq.sv
// Directed bench for z80_bus_seq: a driver issues cycles and queues the expected
// per-cycle strobe profile; a monitor measures each cycle and compares on done.
module tb_z80_bus_seq;
  import z80_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cen = 1'b1;
  logic        req = 1'b0;
  logic [2:0]  req_type = '0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [15:0] rfsh_addr = '0;
  logic [7:0]  di = '0;
  logic        wait_n = 1'b1;
  logic        busrq_n = 1'b1;
  logic        ready, done, busak_n, bus_oe;
  logic [7:0]  rdata, dout;
  logic [15:0] a;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [2:0]  tstate;
  logic        cen_alt = 1'b0;

  z80_bus_seq dut (
    .clk(clk), .reset_n(reset_n), .cen(cen), .req(req), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .rfsh_addr(rfsh_addr), .di(di),
    .ready(ready), .done(done), .rdata(rdata), .wait_n(wait_n), .busrq_n(busrq_n),
    .busak_n(busak_n), .bus_oe(bus_oe), .A(a), .dout(dout), .m1_n(m1_n),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .tstate(tstate)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    cen = cen_alt ? ~cen : 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  tcnt, m1, mreq, iorq, rd, wr, rfsh, gap;
    logic [15:0] addr, raddr;
    logic [7:0]  rdata, dout;
    logic        chk_rd, chk_wr, chk_rf;
  } exp_t;
  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk_exp(
    input int tcnt, input int m1, input int mreq, input int iorq, input int rd,
    input int wr, input int rfsh, input int gap, input logic [15:0] addr,
    input logic [15:0] raddr, input logic [7:0] rd_val, input logic [7:0] wd_val,
    input logic chk_rd, input logic chk_wr, input logic chk_rf);
    exp_t e;
    e.tcnt = 8'(tcnt); e.m1 = 8'(m1); e.mreq = 8'(mreq); e.iorq = 8'(iorq);
    e.rd = 8'(rd); e.wr = 8'(wr); e.rfsh = 8'(rfsh); e.gap = 8'(gap);
    e.addr = addr; e.raddr = raddr; e.rdata = rd_val; e.dout = wd_val;
    e.chk_rd = chk_rd; e.chk_wr = chk_wr; e.chk_rf = chk_rf;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int          c_t, c_m1, c_mreq, c_iorq, c_rd, c_wr, c_rf;
  int          clk_cnt = 0;
  int          last_done = 0;
  logic [15:0] cap_a, cap_ra;
  logic [7:0]  cap_do;
  exp_t        mon_e;

  task automatic clear_mon();
    c_t = 0; c_m1 = 0; c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_rf = 0;
    cap_a = '0; cap_ra = '0; cap_do = '0;
  endtask

  initial clear_mon();

  always @(negedge clk) begin
    clk_cnt++;
    if (!reset_n) begin
      clear_mon();
    end else begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_t'(exp_q.pop_front());
          check("t_states", c_t, mon_e.tcnt);
          check("m1_low_clks", c_m1, mon_e.m1);
          check("mreq_low_clks", c_mreq, mon_e.mreq);
          check("iorq_low_clks", c_iorq, mon_e.iorq);
          check("rd_low_clks", c_rd, mon_e.rd);
          check("wr_low_clks", c_wr, mon_e.wr);
          check("rfsh_low_clks", c_rf, mon_e.rfsh);
          check("addr_t1", cap_a, mon_e.addr);
          if (mon_e.chk_rf) check("rfsh_addr", cap_ra, mon_e.raddr);
          if (mon_e.chk_rd) check("rdata", rdata, mon_e.rdata);
          if (mon_e.chk_wr) check("dout", cap_do, mon_e.dout);
          if (mon_e.gap != 0) check("done_gap", clk_cnt - last_done, mon_e.gap);
        end
        last_done = clk_cnt;
        clear_mon();
      end
      if (tstate inside {TS_T1, TS_T2, TS_TW, TS_T3, TS_T4}) begin
        if (c_t == 0) cap_a = a;
        c_t++;
      end
      if (!m1_n)   c_m1++;
      if (!mreq_n) c_mreq++;
      if (!iorq_n) c_iorq++;
      if (!rd_n)   c_rd++;
      if (!wr_n)   begin c_wr++; cap_do = dout; end
      if (!rfsh_n) begin c_rf++; cap_ra = a; end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] t, input logic [15:0] ad, input logic [7:0] wd,
                       input bit push, input exp_t e);
    int g = 0;
    req = 1'b1; req_type = t; req_addr = ad; req_wdata = wd;
    while (!(ready && cen) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("accept_in_time", (g < 100), 1);
    if (push) exp_q.push_back(W'(e));
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (tstate != TS_IDLE && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("idle_in_time", (g < 100), 1);
  endtask

  task automatic check_strobes_high(input string name);
    check(name, {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}, 6'h3F);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tstate", tstate, TS_IDLE);
    check_strobes_high("rst_strobes");
    check("rst_busak_oe_done", {busak_n, bus_oe, done}, 3'b110);
    check("rst_regs", {a, dout, rdata}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_idle", ready, 1);

    // Abort an IORD in TW with reset: no done, rdata not updated.
    wait_n = 1'b0; di = 8'h5A;
    issue(CYC_IORD, 16'h0042, 8'h00, 1'b0, mk_exp(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (3) @(negedge clk);
    check("abort_in_tw", tstate, TS_TW);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_tstate", tstate, TS_IDLE);
    check_strobes_high("abort_strobes");
    check("abort_done", done, 0);
    check("abort_rdata", rdata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1; wait_n = 1'b1;
    repeat (8) @(negedge clk);

    // MEMRD, no waits.
    di = 8'hA5;
    issue(CYC_MEMRD, 16'h1234, 8'h00, 1'b1,
          mk_exp(3,0,2,0,2,0,0,0,16'h1234,16'h0,8'hA5,8'h00,1,0,0));
    wait_idle();

    // IOWR: one auto wait plus wait_n held low through TW2 -> three TW.
    wait_n = 1'b0;
    issue(CYC_IOWR, 16'h00FE, 8'h3C, 1'b1,
          mk_exp(6,0,0,5,0,5,0,0,16'h00FE,16'h0,8'h00,8'h3C,0,1,0));
    repeat (4) @(negedge clk);
    wait_n = 1'b1;
    wait_idle();

    // M1 with refresh.
    rfsh_addr = 16'h3F7A; di = 8'h3E;
    issue(CYC_M1, 16'h0100, 8'h00, 1'b1,
          mk_exp(4,2,2,0,1,0,2,0,16'h0100,16'h3F7A,8'h3E,8'h00,1,0,1));
    wait_idle();

    // MEMWR chained into MEMRD with req held.
    di = 8'h77;
    issue(CYC_MEMWR, 16'h8000, 8'h5C, 1'b1,
          mk_exp(3,0,2,0,0,2,0,0,16'h8000,16'h0,8'h00,8'h5C,0,1,0));
    issue(CYC_MEMRD, 16'h8001, 8'h00, 1'b1,
          mk_exp(3,0,2,0,2,0,0,3,16'h8001,16'h0,8'h77,8'h00,1,0,0));
    wait_idle();

    // INTA at half rate, bus request during the cycle -> GRANT after T4.
    cen_alt = 1'b1; rfsh_addr = 16'h1B2C; di = 8'hC7;
    issue(CYC_INTA, 16'h0038, 8'h00, 1'b1,
          mk_exp(12,8,2,4,0,0,4,0,16'h0038,16'h1B2C,8'hC7,8'h00,1,0,1));
    repeat (3) @(negedge clk);
    busrq_n = 1'b0;
    g = 0;
    while (busak_n !== 1'b0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("grant_in_time", (g < 60), 1);
    check("grant_tstate", tstate, TS_GRANT);
    check("grant_busak_oe", {busak_n, bus_oe}, 2'b00);
    check_strobes_high("grant_strobes");
    check("grant_ready", ready, 0);
    req = 1'b1; req_type = 3'd1;
    repeat (4) @(negedge clk);
    check("grant_ignores_req", tstate, TS_GRANT);
    req = 1'b0;
    busrq_n = 1'b1;
    wait_idle();
    check("release_busak_oe", {busak_n, bus_oe}, 2'b11);
    cen_alt = 1'b0;
    repeat (4) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
